// File: rtl/filter_cond_pkg.sv
// Shared types for the engine filter-condition pipeline: compare opcodes,
// per-packet configuration record and drain-FSM states.
package filter_cond_pkg;

  localparam int FC_NUM_FIELDS = 4;
  localparam int FC_DATA_W     = 32;

  typedef enum logic [2:0] {
    FC_NOP = 3'd0,
    FC_GT  = 3'd1,
    FC_LT  = 3'd2,
    FC_EQ  = 3'd3,
    FC_NE  = 3'd4,
    FC_GE  = 3'd5,
    FC_LE  = 3'd6
  } filter_cond_op_e;

  typedef struct packed {
    logic [FC_DATA_W-1:0]                         const_value;
    logic [FC_NUM_FIELDS-1:0]                     const_mask;
    logic [FC_NUM_FIELDS-1:0][FC_NUM_FIELDS-1:0]  ops_mask;
    logic [FC_NUM_FIELDS-1:0]                     filter_mask;
    filter_cond_op_e                              op;
    logic                                         signed_cmp;
    logic                                         reduce_or;
    logic                                         drop_fail;
  } filter_cond_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } filter_cond_state_e;

  // Encoding 3'd7 is unassigned; a packet seeing it gets a pass verdict.
  function automatic logic op_defined(input filter_cond_op_e op);
    return (3'(op) <= 3'd6);
  endfunction

endpackage

// File: rtl/filter_cond_cmp_lane.sv
// One field comparator: applies the configured relational op to two operands,
// either unsigned or two's-complement over DATA_W bits.
module filter_cond_cmp_lane
  import filter_cond_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  filter_cond_op_e   op_i,
  input  logic              signed_cmp_i,
  output logic              cmp_o
);

  logic signed [DATA_W:0] a_x;
  logic signed [DATA_W:0] b_x;
  logic                   gt;
  logic                   lt;
  logic                   eq;

  // One extra bit lets a single signed compare serve both modes.
  always_comb begin
    a_x = {signed_cmp_i & a_i[DATA_W-1], a_i};
    b_x = {signed_cmp_i & b_i[DATA_W-1], b_i};
    gt  = (a_x > b_x);
    lt  = (a_x < b_x);
    eq  = (a_i == b_i);
    case (op_i)
      FC_NOP:  cmp_o = 1'b1;
      FC_GT:   cmp_o = gt;
      FC_LT:   cmp_o = lt;
      FC_EQ:   cmp_o = eq;
      FC_NE:   cmp_o = ~eq;
      FC_GE:   cmp_o = gt | eq;
      FC_LE:   cmp_o = lt | eq;
      default: cmp_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/engine_filter_cond_pipe.sv
// Elastic 3-stage filter-condition pipeline (operand select, compare, reduce).
// Define FILTER_COND_STATS_EN to add saturating pass/drop verdict counters.
module engine_filter_cond_pipe
  import filter_cond_pkg::*;
#(
  parameter int NUM_FIELDS = FC_NUM_FIELDS,
  parameter int DATA_W     = FC_DATA_W,
  parameter int CNT_W      = 32
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst_n,
  input  logic                           clear,
  input  logic                           config_params_valid,
  input  filter_cond_cfg_t               config_params,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_FIELDS*DATA_W-1:0]   in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_FIELDS*DATA_W-1:0]   out_data,
  output logic                           out_bool,
  output logic                           idle
`ifdef FILTER_COND_STATS_EN
  ,
  output logic [CNT_W-1:0]               stat_pass,
  output logic [CNT_W-1:0]               stat_drop
`endif
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic reduce_verdict(input logic [NUM_FIELDS-1:0] cmp,
                                          input logic [NUM_FIELDS-1:0] mask,
                                          input logic                  any_mode,
                                          input logic                  op_ok);
    if (!op_ok || (mask == '0)) return 1'b1;
    if (any_mode) return |(cmp & mask);
    return &(cmp | ~mask);
  endfunction

  filter_cond_state_e state_q, state_d;

  logic [NUM_FIELDS-1:0][DATA_W-1:0] fld;
  logic [NUM_FIELDS-1:0][DATA_W-1:0] opnd_d;
  logic [NUM_FIELDS-1:0][DATA_W-1:0] opnd_p0_q;
  logic [NUM_FIELDS*DATA_W-1:0]      fld_p0_q;
  logic [NUM_FIELDS*DATA_W-1:0]      fld_p1_q;
  logic [NUM_FIELDS*DATA_W-1:0]      out_data_q;
  logic [NUM_FIELDS-1:0]             cmp_d;
  logic [NUM_FIELDS-1:0]             cmp_p1_q;
  logic                              vld_p0_q, vld_p1_q, vld_p2_q;
  logic                              en_p0, en_p1, en_p2;
  logic                              in_fire;
  logic                              bool_d, keep_d;
  logic                              out_bool_q;
  logic                              pipe_empty;

  assign fld = in_data;

  assign en_p2      = !vld_p2_q || out_ready;
  assign en_p1      = !vld_p1_q || en_p2;
  assign en_p0      = !vld_p0_q || en_p1;
  assign in_ready   = (state_q == ST_RUN) && en_p0;
  assign in_fire    = in_valid && in_ready;
  assign pipe_empty = !vld_p0_q && !vld_p1_q && !vld_p2_q;

  assign out_valid = vld_p2_q;
  assign out_data  = out_data_q;
  assign out_bool  = out_bool_q;
  assign idle      = (state_q == ST_IDLE) && pipe_empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (config_params_valid && !clear) state_d = ST_RUN;
      ST_RUN:   if (clear || !config_params_valid) state_d = ST_DRAIN;
      ST_DRAIN: if (pipe_empty) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Stage 0: operand select (const overrides routing; highest routed field wins)
  always_comb begin
    opnd_d = fld;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      for (int j = 0; j < NUM_FIELDS; j++) begin
        if (config_params.ops_mask[i][j]) opnd_d[i] = fld[j];
      end
      if (config_params.const_mask[i]) opnd_d[i] = config_params.const_value;
    end
  end

  // Stage 1: per-field compare against the next operand (wrapping)
  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_lane
    filter_cond_cmp_lane #(
      .DATA_W(DATA_W)
    ) u_lane (
      .a_i          (opnd_p0_q[g]),
      .b_i          (opnd_p0_q[(g + 1) % NUM_FIELDS]),
      .op_i         (config_params.op),
      .signed_cmp_i (config_params.signed_cmp),
      .cmp_o        (cmp_d[g])
    );
  end

  // Stage 2: reduce to a verdict; failing packets may be discarded here
  assign bool_d = reduce_verdict(cmp_p1_q, config_params.filter_mask,
                                 config_params.reduce_or, op_defined(config_params.op));
  assign keep_d = !(config_params.drop_fail && !bool_d);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      out_data_q <= '0;
      out_bool_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (en_p0) vld_p0_q <= in_fire;
      if (en_p1) vld_p1_q <= vld_p0_q;
      if (en_p2) begin
        vld_p2_q <= vld_p1_q && keep_d;
        if (vld_p1_q && keep_d) begin
          out_data_q <= fld_p1_q;
          out_bool_q <= bool_d;
        end
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (in_fire) begin
      fld_p0_q  <= in_data;
      opnd_p0_q <= opnd_d;
    end
    if (en_p1 && vld_p0_q) begin
      fld_p1_q <= fld_p0_q;
      cmp_p1_q <= cmp_d;
    end
  end

`ifdef FILTER_COND_STATS_EN
  logic [CNT_W-1:0] pass_q, drop_q;

  // A verdict is counted when it leaves stage 1, dropped or not.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || clear) begin
      pass_q <= '0;
      drop_q <= '0;
    end else if (vld_p1_q && en_p2) begin
      if (bool_d) pass_q <= sat_inc(pass_q);
      else        drop_q <= sat_inc(drop_q);
    end
  end

  assign stat_pass = pass_q;
  assign stat_drop = drop_q;
`endif

endmodule
